f_multiplier: RTL and testbench

F_MULTIPLIER -- requirements
Module: f_multiplier

---
 rtl/f_multiplier_if.sv | 32 +++
 rtl/f_multiplier.sv | 246 ++++++++++++++++++++++++
 tb/tb_f_multiplier.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/f_multiplier_if.sv
// -----------------------------------------------------------------------------
// f_multiplier_if
//   Operand/result bundle for the binary32 multiplier.
//
//   Signals
//     in0  : operand A, binary32 {sign, exp[7:0], frac[22:0]}
//     in1  : operand B, binary32
//     out  : registered product in0*in1, binary32
//
//   Modports
//     master : drives the operands, observes the product (testbench / source)
//     slave  : consumes the operands, drives the product (f_multiplier)
// -----------------------------------------------------------------------------
interface f_multiplier_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] in0;
    logic [BIT_WIDTH-1:0] in1;
    logic [BIT_WIDTH-1:0] out;

    modport master (
        output in0,
        output in1,
        input  out
    );

    modport slave (
        input  in0,
        input  in1,
        output out
    );
endinterface : f_multiplier_if

// File: rtl/f_multiplier.sv
// -----------------------------------------------------------------------------
// f_multiplier
//   IEEE-754 binary32 multiplier, 3-stage pipeline, one result per cycle,
//   no handshake and no stall. A result appears on bus.out exactly three
//   rising edges after its operands are sampled.
//
//   Stage 1 : unpack, classify (zero / normal / inf / NaN), flush denormal
//             inputs to signed zero, form the unbiased exponent sum.
//   Stage 2 : 24x24 mantissa multiply.
//   Stage 3 : normalize (product is in [1,4)), round, overflow/underflow
//             handling, pack into the output register.
//
//   Ports
//     clk   : single clock, all state updates on the rising edge
//     rstn  : asynchronous reset, ACTIVE-HIGH despite the name; clears every
//             pipeline register and bus.out to zero while asserted
//     bus   : f_multiplier_if.slave (in0, in1 in; out out)
//
//   Parameter
//     BIT_WIDTH : operand/result width; only 32 is supported
//
//   Build option
//     F_MULTIPLIER_ROUND_NEAREST_EN
//       defined   : round-to-nearest-ties-to-even over all 48 product bits
//       undefined : truncation (round toward zero)
//     Latency and special-case behaviour are identical in both builds.
// -----------------------------------------------------------------------------
module f_multiplier #(
    parameter int BIT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    f_multiplier_if.slave    bus
);

    if (BIT_WIDTH != 32) begin : g_bad_width
        $error("f_multiplier supports only BIT_WIDTH = 32 (binary32)");
    end

    // CLS_ZERO is encoded as all-zeros so a cleared pipeline packs to +0.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // -------------------------------------------------------------------------
    // Stage 1 : unpack and classify
    // -------------------------------------------------------------------------
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic        a_nan;
    logic        b_nan;

    logic               s1_sign_d;
    cls_t               s1_cls_d;
    logic signed [9:0]  s1_exp_d;
    logic [23:0]        s1_mant_a_d;
    logic [23:0]        s1_mant_b_d;

    logic               s1_sign_q;
    cls_t               s1_cls_q;
    logic signed [9:0]  s1_exp_q;
    logic [23:0]        s1_mant_a_q;
    logic [23:0]        s1_mant_b_q;

    always_comb begin
        a_exp  = bus.in0[30:23];
        b_exp  = bus.in1[30:23];
        a_frac = bus.in0[22:0];
        b_frac = bus.in1[22:0];

        // exp == 0 covers both true zero and denormals; denormals are
        // flushed to signed zero, so both classify as zero.
        a_zero = (a_exp == 8'h00);
        b_zero = (b_exp == 8'h00);
        a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
        b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
        a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
        b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

        s1_sign_d = bus.in0[31] ^ bus.in1[31];

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_cls_d = CLS_NAN;
        end else if (a_inf || b_inf) begin
            s1_cls_d = CLS_INF;
        end else if (a_zero || b_zero) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORM;
        end

        // Range -125..381 fits comfortably in a signed 10-bit value, leaving
        // headroom for the two possible +1 adjustments in stage 3.
        s1_exp_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;

        // Special results never look at the mantissas; keep the multiplier
        // inputs quiet for them.
        if (s1_cls_d == CLS_NORM) begin
            s1_mant_a_d = {1'b1, a_frac};
            s1_mant_b_d = {1'b1, b_frac};
        end else begin
            s1_mant_a_d = 24'd0;
            s1_mant_b_d = 24'd0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_exp_q    <= '0;
            s1_mant_a_q <= '0;
            s1_mant_b_q <= '0;
        end else begin
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_a_q <= s1_mant_a_d;
            s1_mant_b_q <= s1_mant_b_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 : mantissa multiply
    // -------------------------------------------------------------------------
    logic [47:0]        s2_prod_d;

    logic               s2_sign_q;
    cls_t               s2_cls_q;
    logic signed [9:0]  s2_exp_q;
    logic [47:0]        s2_prod_q;

    always_comb begin
        s2_prod_d = s1_mant_a_q * s1_mant_b_q;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            s2_sign_q <= 1'b0;
            s2_cls_q  <= CLS_ZERO;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
        end else begin
            s2_sign_q <= s1_sign_q;
            s2_cls_q  <= s1_cls_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= s2_prod_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3 : normalize, round, pack
    // -------------------------------------------------------------------------
    logic [22:0]        frac_norm;
    logic signed [9:0]  exp_norm;
    logic               round_inc;
    logic [23:0]        frac_rnd;
    logic [22:0]        frac_fin;
    logic signed [9:0]  exp_fin;

    logic [31:0]        out_d;
    logic [31:0]        out_q;

`ifndef F_MULTIPLIER_ROUND_NEAREST_EN
    // Truncation never looks below the kept mantissa bits.
    logic unused_prod_lsbs;
    assign unused_prod_lsbs = |s2_prod_q[22:0];
`endif

    always_comb begin
        frac_norm = '0;
        exp_norm  = '0;
        round_inc = 1'b0;
        frac_rnd  = '0;
        frac_fin  = '0;
        exp_fin   = '0;
        out_d     = '0;

        // Product of two [1,2) mantissas lies in [1,4): bit 47 set means
        // the value is in [2,4) and needs one extra exponent step.
        if (s2_prod_q[47]) begin
            frac_norm = s2_prod_q[46:24];
            exp_norm  = s2_exp_q + 10'sd1;
        end else begin
            frac_norm = s2_prod_q[45:23];
            exp_norm  = s2_exp_q;
        end

`ifdef F_MULTIPLIER_ROUND_NEAREST_EN
        // Round bit and sticky are merged: only "above half" vs "exactly
        // half" matters, and ties go to the even mantissa.
        if (s2_prod_q[47]) begin
            round_inc = s2_prod_q[23] & (s2_prod_q[24] | (|s2_prod_q[22:0]));
        end else begin
            round_inc = s2_prod_q[22] & (s2_prod_q[23] | (|s2_prod_q[21:0]));
        end
`endif

        // Carry out of the fraction means 1.11..1 rounded up to 10.0; the
        // fraction field is then already zero, only the exponent moves.
        frac_rnd = {1'b0, frac_norm} + {23'd0, round_inc};
        frac_fin = frac_rnd[22:0];
        if (frac_rnd[23]) begin
            exp_fin = exp_norm + 10'sd1;
        end else begin
            exp_fin = exp_norm;
        end

        unique case (s2_cls_q)
            CLS_NAN:  out_d = CANON_NAN;
            CLS_INF:  out_d = {s2_sign_q, 8'hFF, 23'd0};
            CLS_ZERO: out_d = {s2_sign_q, 31'd0};
            default: begin
                if (exp_fin >= 10'sd255) begin
                    out_d = {s2_sign_q, 8'hFF, 23'd0};
                end else if (exp_fin <= 10'sd0) begin
                    out_d = {s2_sign_q, 31'd0};
                end else begin
                    out_d = {s2_sign_q, exp_fin[7:0], frac_fin};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule : f_multiplier

// File: tb/tb_f_multiplier.sv
module tb_f_multiplier;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    f_multiplier_if #(.BIT_WIDTH(32)) bus ();

    f_multiplier #(.BIT_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

`ifdef F_MULTIPLIER_ROUND_NEAREST_EN
    localparam logic [31:0] EXP_RND       = 32'h4010_0002;
    localparam logic [31:0] EXP_CARRY     = 32'h4000_0000;
    localparam logic [31:0] EXP_CARRY_OVF = 32'h7F80_0000;
`else
    localparam logic [31:0] EXP_RND       = 32'h4010_0001;
    localparam logic [31:0] EXP_CARRY     = 32'h3FFF_FFFF;
    localparam logic [31:0] EXP_CARRY_OVF = 32'h7F7F_FFFF;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sa[$];
    logic [31:0] sb[$];
    logic [31:0] se[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: exact 64-bit product, shift to 24 significant
    // bits, round by comparing the discarded remainder against one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [7:0]      ea;
        logic [7:0]      eb;
        logic [22:0]     fa;
        logic [22:0]     fb;
        logic            s;
        bit              za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, p, q, rem, half;
        int              sh;
        int              e;
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        s  = a[31] ^ b[31];
        za = (ea == 8'd0);
        zb = (eb == 8'd0);
        ia = (ea == 8'hFF) && (fa == 23'd0);
        ib = (eb == 8'hFF) && (fb == 23'd0);
        na = (ea == 8'hFF) && (fa != 23'd0);
        nb = (eb == 8'hFF) && (fb != 23'd0);
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC0_0000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        ma   = {40'd0, 1'b1, fa};
        mb   = {40'd0, 1'b1, fb};
        p    = ma * mb;
        sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
        e    = int'(ea) + int'(eb) - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
`ifdef F_MULTIPLIER_ROUND_NEAREST_EN
        if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
`endif
        if (q == 64'h100_0000) begin
            q = 64'h80_0000;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(3, 0) != 0) v[30:23] = 8'($urandom_range(194, 60));
        return v;
    endfunction

    task automatic apply(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] req);
        bus.in0 = a;
        bus.in1 = b;
        repeat (3) step();
        check(name, bus.out, req);
    endtask

    // One vector per cycle; vector i is sampled on edge i and must be on
    // out after edge i+2 (its third edge).
    task automatic run_stream(input string tag);
        int n;
        n = sa.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                bus.in0 = sa[i];
                bus.in1 = sb[i];
            end
            step();
            if (i >= 2) check($sformatf("%s[%0d]", tag, i - 2), bus.out, se[i - 2]);
        end
    endtask

    initial begin
        vecs.push_back(mk(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000));
        vecs.push_back(mk(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000));
        vecs.push_back(mk(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000));
        vecs.push_back(mk(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000));
        vecs.push_back(mk(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000));
        vecs.push_back(mk(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000));
        vecs.push_back(mk(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000));
        vecs.push_back(mk(32'h0080_0000, 32'h0080_0000, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0001, 32'h7F00_0000, 32'h0000_0000));
        vecs.push_back(mk(32'h3FC0_0001, 32'h3FC0_0001, EXP_RND));
        vecs.push_back(mk(32'h3FA1_E58F, 32'h3FCA_6691, EXP_CARRY));
        vecs.push_back(mk(32'h7F21_E58F, 32'h3FCA_6691, EXP_CARRY_OVF));
        vecs.push_back(mk(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000));
        vecs.push_back(mk(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000));
        vecs.push_back(mk(32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000));
        vecs.push_back(mk(32'h7F80_0000, 32'h8000_0001, 32'h7FC0_0000));
        vecs.push_back(mk(32'hC040_0000, 32'hC000_0000, 32'h40C0_0000));
        vecs.push_back(mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF));
        vecs.push_back(mk(32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000));
        vecs.push_back(mk(32'h5F80_0000, 32'h5F80_0000, 32'h7F80_0000));
        vecs.push_back(mk(32'h5F80_0000, 32'h5F00_0000, 32'h7F00_0000));

        // Reset held with live operands: output stays zero.
        rstn    = 1'b1;
        bus.in0 = 32'h3F80_0000;
        bus.in1 = 32'h4000_0000;
        #1;
        check("reset_async_start", bus.out, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("reset_hold[%0d]", i), bus.out, 32'h0000_0000);
        end

        // Release: nothing before the third edge, then 1.0 * 2.0.
        rstn = 1'b0;
        step();
        check("release_edge1", bus.out, 32'h0000_0000);
        step();
        check("release_edge2", bus.out, 32'h0000_0000);
        step();
        check("release_edge3", bus.out, 32'h4000_0000);

        // Directed table, one vector at a time.
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Same table back-to-back, one per cycle.
        sa.delete(); sb.delete(); se.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            sa.push_back(vecs[i].a);
            sb.push_back(vecs[i].b);
            se.push_back(vecs[i].exp);
        end
        run_stream("b2b");

        // Asynchronous reset in the middle of a stream.
        apply("pre_reset", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
        bus.in0 = 32'hC000_0000;
        bus.in1 = 32'h4040_0000;
        step();
        #2;
        rstn = 1'b1;
        #1;
        check("mid_reset_async", bus.out, 32'h0000_0000);
        step();
        check("mid_reset_hold", bus.out, 32'h0000_0000);
        bus.in0 = 32'h4040_0000;
        bus.in1 = 32'h4000_0000;
        rstn    = 1'b0;
        step();
        check("mid_release_edge1", bus.out, 32'h0000_0000);
        step();
        check("mid_release_edge2", bus.out, 32'h0000_0000);
        step();
        check("mid_release_edge3", bus.out, 32'h40C0_0000);

        // Random stream against the reference model.
        sa.delete(); sb.delete(); se.delete();
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = rand_op();
            rb = rand_op();
            sa.push_back(ra);
            sb.push_back(rb);
            se.push_back(ref_mul(ra, rb));
        end
        run_stream("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_f_multiplier
